// File: rtl/seq_datapath.sv
// seq_datapath: register file feeding an ALU with single-cycle logic ops and
// iterative unsigned multiply/divide, sequenced by a start/busy/done FSM.
module seq_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0] ra_sel,
  input  logic [SEL_W-1:0] rb_sel,
  input  logic [3:0]       op_select,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int LW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rf_q [NUM_REGS];
  logic [WIDTH-1:0] a, b, sc_lo, rol_v, ror_v;
  logic [WIDTH-1:0] acc_q, acc_d, w_q, w_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [LW-1:0]    cnt_q, cnt_d, sh;
  logic [LW:0]      rsh;
  logic [WIDTH:0]   add_r, sub_r, mul_s, div_s, div_t;
  logic             sc_hi0, done_q, dz_q, dz_d;

  assign a      = rf_q[ra_sel];
  assign b      = rf_q[rb_sel];
  assign sh     = b[LW-1:0];
  assign rsh    = (LW+1)'(WIDTH) - {1'b0, sh};
  assign add_r  = {1'b0, a} + {1'b0, b};
  assign sub_r  = {1'b0, a} - {1'b0, b};
  assign rol_v  = (a << sh) | (a >> rsh);
  assign ror_v  = (a >> sh) | (a << rsh);
  assign sc_hi0 = op_select == 4'd0 ? add_r[WIDTH] : op_select == 4'd1 ? sub_r[WIDTH] : 1'b0;

  always_comb begin
    sc_lo = '0;
    case (op_select)
      4'd0:    sc_lo = add_r[WIDTH-1:0];
      4'd1:    sc_lo = sub_r[WIDTH-1:0];
      4'd2:    sc_lo = a & b;
      4'd3:    sc_lo = a | b;
      4'd4:    sc_lo = a ^ b;
      4'd5:    sc_lo = ~a;
      4'd6:    sc_lo = -a;
      4'd7:    sc_lo = a << sh;
      4'd8:    sc_lo = a >> sh;
      4'd9:    sc_lo = $signed(a) >>> sh;
      4'd10:   sc_lo = rol_v;
      4'd11:   sc_lo = ror_v;
      default: sc_lo = '0;
    endcase
  end

  // One shift-add step (acc:w holds the partial product) and one restoring
  // division step (acc is the partial remainder, w shifts dividend out / quotient in).
  assign mul_s = w_q[0] ? {1'b0, acc_q} + {1'b0, b_q} : {1'b0, acc_q};
  assign div_s = {acc_q, w_q[WIDTH-1]};
  assign div_t = div_s - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    w_d     = w_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start) begin
        dz_d = 1'b0;
        if (op_select == 4'd12 || (op_select == 4'd13 && b != '0)) begin
          state_d = op_select == 4'd12 ? MUL : DIV;
          acc_d   = '0;
          w_d     = a;
          b_d     = b;
          cnt_d   = LW'(WIDTH - 1);
        end else if (op_select == 4'd13) begin
          state_d = FIN;
          hi_d    = a;
          lo_d    = '1;
          dz_d    = 1'b1;
        end else begin
          state_d = FIN;
          hi_d    = {{(WIDTH-1){1'b0}}, sc_hi0};
          lo_d    = sc_lo;
        end
      end
      MUL, DIV: begin
        acc_d = state_q == MUL ? mul_s[WIDTH:1] : div_t[WIDTH] ? div_s[WIDTH-1:0] : div_t[WIDTH-1:0];
        w_d   = state_q == MUL ? {mul_s[0], w_q[WIDTH-1:1]} : {w_q[WIDTH-2:0], ~div_t[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          cnt_d   = '0;
          hi_d    = acc_d;
          lo_d    = w_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      state_q <= IDLE;
      acc_q   <= '0;
      w_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (wr_en) rf_q[wr_sel] <= wr_data;
      state_q <= state_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= state_q == FIN;
    end

  assign busy     = state_q == MUL || state_q == DIV;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: random and directed stimulus against a behavioural model of
// the datapath, plus a small directed check of an 8-bit instance.
module tb_seq_datapath;
  logic clk = 0, clear = 0;
  always #5 clk = ~clk;

  logic        wr_en = 0, start = 0, busy, done, dz;
  logic [3:0]  wr_sel = 0, ra_sel = 0, rb_sel = 0, op = 0;
  logic [31:0] wr_data = 0, hi, lo;

  logic       wr_en8 = 0, start8 = 0, busy8, done8, dz8;
  logic [1:0] wr_sel8 = 0, ra_sel8 = 0, rb_sel8 = 0;
  logic [3:0] op8 = 0;
  logic [7:0] wr_data8 = 0, hi8, lo8;

  seq_datapath u_dut (
    .clock(clk), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .op_select(op), .start(start),
    .busy(busy), .done(done), .div_zero(dz), .hi(hi), .lo(lo));

  seq_datapath #(.WIDTH(8), .NUM_REGS(4)) u_dut8 (
    .clock(clk), .clear(clear), .wr_en(wr_en8), .wr_sel(wr_sel8), .wr_data(wr_data8),
    .ra_sel(ra_sel8), .rb_sel(rb_sel8), .op_select(op8), .start(start8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

  int n_tot = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl,
                                 output logic rdz, output int rlat);
    logic [63:0] w;
    int s;
    s = int'(b % 32);
    rh = 0; rl = 0; rdz = 0; rlat = 0;
    case (o)
      4'd0: begin w = {32'd0, a} + {32'd0, b}; rl = w[31:0]; rh = {31'd0, w[32]}; end
      4'd1: begin rl = a - b; rh = {31'd0, a < b}; end
      4'd2: rl = a & b;
      4'd3: rl = a | b;
      4'd4: rl = a ^ b;
      4'd5: rl = ~a;
      4'd6: rl = 32'd0 - a;
      4'd7: rl = a << s;
      4'd8: rl = a >> s;
      4'd9: rl = $signed(a) >>> s;
      4'd10: rl = (s == 0) ? a : (a << s) | (a >> (32 - s));
      4'd11: rl = (s == 0) ? a : (a >> s) | (a << (32 - s));
      4'd12: begin w = {32'd0, a} * {32'd0, b}; rh = w[63:32]; rl = w[31:0]; rlat = 32; end
      4'd13: if (b == 0) begin rh = a; rl = '1; rdz = 1; end
             else begin rl = a / b; rh = a % b; rlat = 32; end
      default: ;
    endcase
  endfunction

  // Timeline model: an accepted op writes Z `lat` edges later and pulses done one edge after that.
  logic [31:0] mrf [16];
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_busy = 0, m_done = 0, m_dz = 0;
  bit          act = 0;
  int          cyc = 0, lat = 0;

  always @(posedge clk or negedge clear)
    if (!clear) begin
      act = 0; cyc = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
      foreach (mrf[i]) mrf[i] = 0;
    end else begin
      if (act) begin
        cyc++;
        if (cyc == lat) begin m_hi = p_hi; m_lo = p_lo; end
        m_busy = cyc < lat;
        m_done = cyc == lat + 1;
        if (m_done) act = 0;
      end else begin
        m_done = 0;
        if (start) begin
          ref_op(op, mrf[ra_sel], mrf[rb_sel], p_hi, p_lo, m_dz, lat);
          act = 1; cyc = 0; m_busy = lat > 0;
          if (lat == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end
      if (wr_en) mrf[wr_sel] = wr_data;
    end

  always @(negedge clk)
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_zero", dz, m_dz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end

  task automatic wr(input logic [3:0] s, input logic [31:0] d);
    wr_en = 1; wr_sel = s; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic go(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
    start = 1; op = o; ra_sel = a; rb_sel = b;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int max, output int n, output int nb);
    n = 0; nb = int'(busy);
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end
    check("done_within_bound", done, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  t_op [3] = '{4'd12, 4'd13, 4'd10};
  logic [7:0]  t_a  [3] = '{8'hFF, 8'd200, 8'h81};
  logic [7:0]  t_b  [3] = '{8'hFF, 8'd7, 8'd1};
  logic [15:0] t_e  [3] = '{16'hFE01, 16'h041C, 16'h0003};
  int          t_l  [3] = '{10, 10, 2};

  initial begin
    int n, nb, dc;
    repeat (2) @(negedge clk);
    clear = 1; chk_en = 1;
    wr(3, 32'h1234); go(0, 3, 3); wait_done(5, n, nb);
    check("add_r3", lo, 32'h2468);
    #2 clear = 0;
    #1 check("rst_lo", lo, 0); check("rst_hi", hi, 0); check("rst_busy", busy, 0); check("rst_done", done, 0);
    #1 clear = 1;
    @(negedge clk);
    go(0, 3, 3); wait_done(5, n, nb);
    check("r3_cleared", lo, 0);
    wr(1, 32'hFFFF_FFFF); wr(2, 32'h2); go(0, 1, 2); wait_done(5, n, nb);
    check("add_lo", lo, 32'h1); check("add_carry", hi, 32'h1); check("add_done_wait", n, 1);
    wr(2, 32'hFFFF_FFFF); go(12, 1, 2); wait_done(50, n, nb);
    check("mul_hi", hi, 32'hFFFF_FFFE); check("mul_lo", lo, 32'h1);
    check("mul_latency", n + 1, 34); check("mul_busy_cycles", nb, 32);
    wr(1, 32'd100); wr(2, 32'd7); go(13, 1, 2);
    wr(1, 32'd0); go(0, 1, 2); wait_done(50, n, nb);
    check("div_quot", lo, 32'd14); check("div_rem", hi, 32'd2);
    go(0, 1, 2); wait_done(5, n, nb);
    check("write_during_busy", lo, 32'd7);
    wr(1, 32'h55); wr(2, 32'h0); go(13, 1, 2); wait_done(5, n, nb);
    check("dz_lo", lo, 32'hFFFF_FFFF); check("dz_hi", hi, 32'h55);
    check("dz_flag", dz, 1); check("dz_done_wait", n, 1);
    go(0, 1, 2); wait_done(5, n, nb);
    check("dz_cleared", dz, 0);
    wr(1, 32'hFFFF_FFFF); wr(2, 32'hFFFF_FFFF); go(12, 1, 2);
    repeat (9) @(negedge clk);
    #2 clear = 0;
    #1 check("abort_busy", busy, 0);
    #1 clear = 1;
    dc = 0;
    repeat (40) begin @(negedge clk); dc += int'(done); end
    check("abort_no_done", dc, 0);
    wr(1, 32'h8000_0001); wr(2, 32'd1); go(11, 1, 2); wait_done(5, n, nb);
    check("ror", lo, 32'hC000_0000);

    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom % 3) == 0; wr_sel = 4'($urandom); wr_data = pick();
      ra_sel = 4'($urandom); rb_sel = 4'($urandom); op = 4'($urandom);
      start = ($urandom % 4) == 0;
      @(negedge clk);
    end
    wr_en = 0; start = 0;
    for (int i = 0; i < 40 && act; i++) @(negedge clk);
    check("drain", act, 0);

    for (int i = 0; i < 3; i++) begin
      wr_en8 = 1; wr_sel8 = 1; wr_data8 = t_a[i];
      @(negedge clk);
      wr_sel8 = 2; wr_data8 = t_b[i];
      @(negedge clk);
      wr_en8 = 0; op8 = t_op[i]; ra_sel8 = 1; rb_sel8 = 2; start8 = 1;
      @(negedge clk);
      start8 = 0; n = 0;
      while (!done8 && n < 30) begin @(negedge clk); n++; end
      check("w8_result", {hi8, lo8}, t_e[i]);
      check("w8_latency", n + 1, t_l[i]);
      @(negedge clk);
    end
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised datapath core: a `NUM_REGS`-entry general register file, two operand ports, and an ALU that writes a `2*WIDTH`-bit Z result (`hi`/`lo`). Logic ops complete in one cycle. Unsigned multiply and divide run iteratively over `WIDTH` cycles, under a start/busy/done handshake. The control unit sequences it: it writes registers, selects operands, and launches operations.

## Interface
Parameters:
- `WIDTH`, 32: data width of registers, operands, `hi` and `lo`.
- `NUM_REGS`, 16: register file depth, at least 2.
- `SEL_W`, `$clog2(NUM_REGS)`: width of the register select ports.

Ports:
- `clock`, in, 1: rising-edge clock.
- `clear`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: register file write enable.
- `wr_sel`, in, `SEL_W`: write address.
- `wr_data`, in, `WIDTH`: write data.
- `ra_sel`, `rb_sel`, in, `SEL_W`: operand A and operand B register selects.
- `op_select`, in, 4: operation code.
- `start`, in, 1: launch an operation.
- `busy`, out, 1: a multi-cycle operation is in progress.
- `done`, out, 1: one-cycle pulse, result valid.
- `div_zero`, out, 1: the last DIV had a zero divisor; sticky until the next `start`.
- `hi`, out, `WIDTH`: Z upper half.
- `lo`, out, `WIDTH`: Z lower half.

## Operation
- **Register file.**
  - Reads are combinational.
  - Writes occur on the rising edge when `wr_en`=1.
  - All entries are writable; no entry is hardwired to zero.
  - Writes are allowed while `busy`=1, because operands are latched at `start`.
- **Opcodes.** A and B are the latched operands.
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 NEG A.
  - 7 SHL, 8 SHR (logical), 9 SRA, 10 ROL, 11 ROR; the shift amount is `B[$clog2(WIDTH)-1:0]`.
  - 12 MUL, 13 DIV.
  - 14–15 are reserved and behave as single-cycle ops producing zero.
- **Single-cycle ops.**
  - `lo` = result truncated to `WIDTH` bits.
  - `hi` = 0, except ADD, where `hi[0]` = carry out, and SUB, where `hi[0]` = borrow.
- **MUL.** Unsigned shift-add, one bit per cycle. `{hi,lo}` = A*B, full `2*WIDTH` bits.
- **DIV.** Unsigned restoring division, one quotient bit per cycle. `lo` = A/B, `hi` = A%B.
- **Divide by zero (B=0).**
  - No iteration is performed.
  - `lo` = all ones, `hi` = A, `div_zero`=1.
  - Single-cycle timing applies.
- **FSM states:** IDLE, MUL, DIV, FIN.
  - IDLE + `start` + single-cycle op, or DIV with B=0: write Z and go to FIN.
  - IDLE + `start` + MUL: go to MUL. IDLE + `start` + DIV with B≠0: go to DIV. In both cases latch A and B, clear the accumulator, and load the counter with `WIDTH-1`.
  - MUL/DIV: perform one iteration per cycle. When counter = 0, write Z and go to FIN; otherwise decrement the counter.
  - FIN: go to IDLE and assert `done` for this one cycle.
- **Start rules.**
  - `start` is sampled only in IDLE. It is ignored in MUL, DIV and FIN; no queuing.
  - `op_select`, `ra_sel` and `rb_sel` are sampled at the same edge as `start`.
- **Result holding.**
  - `hi`/`lo` change only when Z is written.
  - They hold their value between operations and during iteration; internal working registers are separate.
- **Reset** (`clear`=0, asynchronous):
  - FSM returns to IDLE.
  - All registers, `hi`, `lo` and the counter are cleared to 0.
  - `busy`, `done` and `div_zero` go to 0.
  - An in-flight MUL/DIV is abandoned with no `done`.

## Timing
- Outputs are registered. `busy` is high exactly in the MUL and DIV states.
- **Single-cycle op**, `start` sampled at edge k:
  - `hi`/`lo` update at edge k.
  - `done`=1 from edge k+1 to edge k+2.
  - Back-to-back launch is possible at edge k+2.
- **MUL/DIV**, `start` sampled at edge k:
  - `busy`=1 from edge k through edge k+`WIDTH`.
  - `hi`/`lo` update at edge k+`WIDTH`.
  - `done`=1 for the cycle after edge k+`WIDTH`+1, and `busy`=0 in that cycle.
  - Total latency from `start` to `done` = `WIDTH`+2 edges.
- **Simultaneous write and operand read:**
  - The operand latch sees the old register value, not the one being written at the same edge.
  - The combinational read shows the new value after that edge.
- **Counter.** The counter is `$clog2(WIDTH)` bits, with no wrap beyond `WIDTH` iterations.
- **Arithmetic wrap.** ADD/SUB wrap modulo 2^`WIDTH`. NEG 0 = 0.

## Test plan
- **Reset.** Write r3=0x1234, then pulse `clear` low mid-cycle → r3, `hi`, `lo`, `busy`, `done` all read 0 immediately.
- **ADD with carry.** r1=0xFFFFFFFF, r2=0x00000002, ADD → `lo`=0x00000001, `hi`=0x00000001, `done` one cycle after `start`.
- **MUL.** r1=0xFFFFFFFF, r2=0xFFFFFFFF, MUL → `busy` for 32 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, and `done` at latency 34.
- **DIV, and busy-time behaviour.** r1=100, r2=7, DIV → `lo`=14, `hi`=2. During `busy`: write r1=0, assert `start` with ADD → result unaffected and the ADD is ignored.
- **Divide by zero.** r1=0x55, r2=0, DIV → `lo`=0xFFFFFFFF, `hi`=0x55, `div_zero`=1, `done` after 1 cycle. A following ADD clears `div_zero`.
- **Abort and parameters.** Reset during MUL at cycle 10 → no `done`, `busy`=0. Re-run ROR 0x80000001 by 1 → `lo`=0xC0000000. Repeat the MUL check with `WIDTH`=8, `NUM_REGS`=4: 0xFF*0xFF = 0xFE01.
